pc_fetch_ctrl: RTL and testbench

Fetch-stage sequencer that owns the program counter and drives the instruction-memory request handshake. It accepts branch/jump redirects from execute and presents fetched instructions to decode on a valid/ready interface. Sits between the PC datapath, instruction memory and decode. A redirect that arrives while a memory request is in flight is held and applied once the stale response has been discarded.

---
 rtl/pc_fetch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage sequencer.
// Owns the program counter and drives the instruction-memory request.
// Presents each fetched word to decode over a valid/ready interface.
// Accepts branch/jump redirects from execute at any time.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When defined, a saturating wait counter tracks request cycles that have no ack.
//   timeout_err_o latches high once the counter reaches MAX_WAIT.
//   When undefined, timeout_err_o is tied to 0.
//
// Handshake semantics:
//   imem: imem_req_o and imem_addr_o stay stable until imem_ack_i is seen.
//         imem_ack_i is a single-cycle pulse that carries imem_rdata_i.
//   decode: a transfer happens on a rising edge where instr_valid_o=1,
//           instr_ready_i=1 and redirect_i=0.
//           A redirect in that cycle drops the held word instead.
//
// dbg_state_o exposes the FSM state, so checkers can bind to it.

module pc_fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int               MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
    output logic [WIDTH-1:0] instr_pc_plus4_o,
    output logic             timeout_err_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] target_aligned;
    logic [WIDTH-1:0] pc_plus4;

    // Clear the low two target bits so the PC always stays word aligned.
    assign target_aligned = redirect_target_i & ALIGN_MASK;
    // Sequential PC. The addition wraps modulo 2^WIDTH on purpose.
    assign pc_plus4       = pc_q + PC_STEP;

    // Next-state and datapath decisions for the fetch sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            ST_IDLE: begin
                // Any ack seen here is a protocol error. It is ignored.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        // The response belongs to the wrong path. Refetch at the target.
                        pc_d = target_aligned;
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        pc_d       = pc_plus4;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect_i) begin
                    // The request must stay on the old address until it is acked.
                    // Park the target in pend_target until then.
                    pend_target_d = target_aligned;
                    state_d       = ST_DISCARD;
                end
            end

            ST_HOLD: begin
                // Acks arriving in this state are ignored.
                if (redirect_i) begin
                    pc_d    = target_aligned;
                    state_d = ST_FETCH;
                end else if (instr_ready_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                if (imem_ack_i) begin
                    // Drop the stale response. A redirect in this same cycle wins.
                    pc_d    = redirect_i ? target_aligned : pend_target_q;
                    state_d = ST_FETCH;
                end else if (redirect_i) begin
                    pend_target_d = target_aligned;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output flags are registered, so they are decoded from the next state.
        req_d   = (state_d == ST_FETCH) || (state_d == ST_DISCARD);
        valid_d = (state_d == ST_HOLD);
    end

    // FSM state, PC datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= {WIDTH{1'b0}};
            instr_q       <= {WIDTH{1'b0}};
            instr_pc_q    <= {WIDTH{1'b0}};
            req_q         <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            req_q         <= req_d;
            valid_q       <= valid_d;
        end
    end

    assign imem_req_o       = req_q;
    assign imem_addr_o      = pc_q;
    assign instr_valid_o    = valid_q;
    assign instr_o          = instr_q;
    assign instr_pc_o       = instr_pc_q;
    assign instr_pc_plus4_o = instr_pc_q + PC_STEP;
    assign dbg_state_o      = state_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             req_entry;

    // A fresh entry into a requesting state restarts the wait count.
    assign req_entry = req_d && (state_d != state_q);

    // Saturating wait counter and sticky timeout flag.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        if (req_entry || imem_ack_i) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (req_q && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if (wait_cnt_d == CNT_MAX) begin
            timeout_err_d = 1'b1;
        end
    end

    // Timeout state registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q    <= {CNT_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed and randomized fetch sequences.
// An expected-result queue is filled when an ack is driven.
// It is drained and compared when decode accepts an instruction.
module tb_pc_fetch_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_i;
  logic [W-1:0] redirect_target_i;
  logic         imem_req_o;
  logic [W-1:0] imem_addr_o;
  logic         imem_ack_i;
  logic [W-1:0] imem_rdata_i;
  logic         instr_valid_o;
  logic         instr_ready_i;
  logic [W-1:0] instr_o;
  logic [W-1:0] instr_pc_o;
  logic [W-1:0] instr_pc_plus4_o;
  logic         timeout_err_o;
  logic [1:0]   dbg_state_o;

  pc_fetch_ctrl #(.WIDTH(W), .RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ack_i        (imem_ack_i),
    .imem_rdata_i      (imem_rdata_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_pc_plus4_o  (instr_pc_plus4_o),
    .timeout_err_o     (timeout_err_o),
    .dbg_state_o       (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];      // expected instruction words
  logic [W-1:0] exp_pc_q[$];   // expected PCs of those words
  logic [W-1:0] exp_pc;        // address the bench expects the next request to use

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock step. A decode transfer is scored from the values seen just before the edge.
  task automatic tick();
    logic [W-1:0] e_pc;
    logic [W-1:0] e_ins;
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_xfer", 32'(instr_valid_o), 32'd0);
      end else begin
        e_ins = exp_q.pop_front();
        e_pc  = exp_pc_q.pop_front();
        check_eq("xfer_instr", instr_o, e_ins);
        check_eq("xfer_pc", instr_pc_o, e_pc);
        check_eq("xfer_pc_plus4", instr_pc_plus4_o, e_pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver: serve one request at exp_pc after lat wait cycles
  task automatic fetch_one(input int lat, input bit keep);
    check_eq("req_up", 32'(imem_req_o), 32'd1);
    check_eq("req_addr", imem_addr_o, exp_pc);
    for (int i = 0; i < lat; i++) begin
      tick();
      check_eq("addr_stable", imem_addr_o, exp_pc);
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_word(exp_pc);
    if (keep) begin
      exp_q.push_back(mem_word(exp_pc));
      exp_pc_q.push_back(exp_pc);
    end
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom();
    check_eq("valid_after_ack", 32'(instr_valid_o), 32'd1);
    check_eq("req_low_hold", 32'(imem_req_o), 32'd0);
    exp_pc = exp_pc + 32'd4;
  endtask

  initial begin
    int c0;
    int lat;
    int hold;
    rst = 1'b0;
    redirect_i = 1'b0;
    redirect_target_i = '0;
    imem_ack_i = 1'b0;
    imem_rdata_i = '0;
    instr_ready_i = 1'b1;
    exp_pc = 32'h0;

    // reset state
    tick();
    tick();
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_instr_pc", instr_pc_o, 32'h0);
    check_eq("rst_err", 32'(timeout_err_o), 32'd0);
    rst = 1'b1;
    check_eq("idle_req", 32'(imem_req_o), 32'd0);
    tick();
    check_eq("first_req", 32'(imem_req_o), 32'd1);

    // streaming with one wait cycle per request: 3 cycles per instruction
    c0 = cyc;
    fetch_one(1, 1'b1);
    tick();
    check_eq("throughput", 32'(cyc - c0), 32'd3);
    fetch_one(1, 1'b1);
    tick();
    instr_ready_i = 1'b0;
    fetch_one(1, 1'b1);

    // hold 0x00500093 at pc 0x8 for 4 cycles; a stray ack must be ignored
    for (int i = 0; i < 4; i++) begin
      check_eq("hold_valid", 32'(instr_valid_o), 32'd1);
      check_eq("hold_instr", instr_o, 32'h0050_0093);
      check_eq("hold_pc", instr_pc_o, 32'h8);
      check_eq("hold_pc4", instr_pc_plus4_o, 32'hC);
      check_eq("hold_noreq", 32'(imem_req_o), 32'd0);
      imem_ack_i   = (i == 1);
      imem_rdata_i = 32'hBAD0_BAD0;
      tick();
      imem_ack_i = 1'b0;
    end
    instr_ready_i = 1'b1;
    tick();

    // redirect while a request is in flight: stale data dropped
    fetch_one(0, 1'b1);
    tick();
    check_eq("pre_redir_addr", imem_addr_o, 32'h10);
    redirect_i = 1'b1;
    redirect_target_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("discard_addr", imem_addr_o, 32'h10);
      check_eq("discard_req", 32'(imem_req_o), 32'd1);
      check_eq("discard_novalid", 32'(instr_valid_o), 32'd0);
      tick();
    end
    imem_ack_i = 1'b1;
    imem_rdata_i = mem_word(32'h10);
    tick();
    imem_ack_i = 1'b0;
    check_eq("drop_novalid", 32'(instr_valid_o), 32'd0);
    check_eq("redir_addr", imem_addr_o, 32'h100);
    exp_pc = 32'h100;
    fetch_one(0, 1'b1);
    tick();

    // two redirects during DISCARD: the latest one wins
    redirect_i = 1'b1;
    redirect_target_i = 32'h200;
    tick();
    redirect_target_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    check_eq("discard2_addr", imem_addr_o, 32'h104);
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    check_eq("latest_wins", imem_addr_o, 32'h300);
    exp_pc = 32'h300;
    // redirect in HOLD drops the word even with ready=1; target bits [1:0] cleared
    fetch_one(0, 1'b0);
    redirect_i = 1'b1;
    redirect_target_i = 32'h203;
    tick();
    redirect_i = 1'b0;
    check_eq("hold_redir_novalid", 32'(instr_valid_o), 32'd0);
    check_eq("aligned_target", imem_addr_o, 32'h200);
    // ack together with a redirect in FETCH
    imem_ack_i = 1'b1;
    redirect_i = 1'b1;
    redirect_target_i = 32'h400;
    tick();
    check_eq("fetch_ackredir_addr", imem_addr_o, 32'h400);
    check_eq("fetch_ackredir_valid", 32'(instr_valid_o), 32'd0);
    check_eq("fetch_ackredir_req", 32'(imem_req_o), 32'd1);
    // ack together with a redirect in DISCARD
    imem_ack_i = 1'b0;
    redirect_target_i = 32'h500;
    tick();
    imem_ack_i = 1'b1;
    redirect_target_i = 32'h600;
    tick();
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
    check_eq("discard_ackredir", imem_addr_o, 32'h600);
    exp_pc = 32'h600;

    // PC wrap at the top of the address space
    fetch_one(0, 1'b0);
    redirect_i = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    fetch_one(0, 1'b1);
    tick();
    check_eq("wrap_addr", imem_addr_o, 32'h0);

    // randomized latency and decode backpressure
    for (int k = 0; k < 8; k++) begin
      lat  = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      instr_ready_i = (hold == 0);
      fetch_one(lat, 1'b1);
      for (int h = 0; h < hold; h++) begin
        check_eq("rnd_hold_valid", 32'(instr_valid_o), 32'd1);
        tick();
      end
      instr_ready_i = 1'b1;
      tick();
    end

    // reset in the middle of a request, then an ack that arrives in IDLE
    check_eq("mid_req", 32'(imem_req_o), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("async_req", 32'(imem_req_o), 32'd0);
    check_eq("async_addr", imem_addr_o, 32'h0);
    check_eq("async_valid", 32'(instr_valid_o), 32'd0);
    tick();
    rst = 1'b1;
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    tick();
    imem_ack_i = 1'b0;
    check_eq("idle_ack_req", 32'(imem_req_o), 32'd1);
    check_eq("idle_ack_addr", imem_addr_o, 32'h0);
    check_eq("idle_ack_valid", 32'(instr_valid_o), 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // timeout: 15 wait cycles without an ack
    for (int i = 0; i < 14; i++) tick();
    check_eq("to_before", 32'(timeout_err_o), 32'd0);
    tick();
    check_eq("to_set", 32'(timeout_err_o), 32'd1);
    check_eq("to_req_held", 32'(imem_req_o), 32'd1);
    instr_ready_i = 1'b0;
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    check_eq("to_sticky", 32'(timeout_err_o), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("to_clear", 32'(timeout_err_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();
`else
    for (int i = 0; i < 20; i++) tick();
    check_eq("no_timeout", 32'(timeout_err_o), 32'd0);
`endif

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
